fu_issue_queue: RTL

Operand issue buffer and result collector for the execute-stage functional unit. It accepts micro-ops (operands A/B, 4-bit function select, destination tag) over a valid/ready handshake and queues them in order. It presents the oldest entry to the combinational FU and captures the FU result and flags into a registered output stage with its own valid/ready handshake. It is the initiator side of the FU interface: it drives A/B/Sel and consumes S/C/V/N/Z.

---
 rtl/fu_issue_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/fu_issue_queue.sv
// In-order operand queue feeding a combinational FU; captures result+flags+tag into a registered output stage.
// Latency 2 cycles in->out; in_ready = not-full (queue only), result stage stalls the head while out_valid && !out_ready.
module fu_issue_queue #(
  parameter int size      = 32,
  parameter int depth     = 4,
  parameter int tag_width = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [size-1:0]            in_a,
  input  logic [size-1:0]            in_b,
  input  logic [3:0]                 in_sel,
  input  logic [tag_width-1:0]       in_tag,
  output logic [size-1:0]            fu_a,
  output logic [size-1:0]            fu_b,
  output logic [3:0]                 fu_sel,
  input  logic [size-1:0]            fu_s,
  input  logic                       fu_c,
  input  logic                       fu_v,
  input  logic                       fu_n,
  input  logic                       fu_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [size-1:0]            out_s,
  output logic [3:0]                 out_flags,
  output logic [tag_width-1:0]       out_tag,
  output logic [$clog2(depth):0]     count
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [size-1:0]      r_a   [depth];
  logic [size-1:0]      r_b   [depth];
  logic [3:0]           r_sel [depth];
  logic [tag_width-1:0] r_tag [depth];

  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_out_vld;
  logic [size-1:0]      r_out_s;
  logic [3:0]           r_out_flags;
  logic [tag_width-1:0] r_out_tag;

  logic w_full;
  logic w_head_vld;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == CW'(depth));
  assign w_head_vld = (r_count != '0);
  assign w_push     = in_valid && !w_full && !flush;
  // Flush wins over capture: the head is discarded, not moved into the result stage.
  assign w_pop      = w_head_vld && (!r_out_vld || out_ready) && !flush;

  assign in_ready  = !w_full;
  assign count     = r_count;
  assign fu_a      = w_head_vld ? r_a[r_rptr]   : '0;
  assign fu_b      = w_head_vld ? r_b[r_rptr]   : '0;
  assign fu_sel    = w_head_vld ? r_sel[r_rptr] : '0;
  assign out_valid = r_out_vld;
  assign out_s     = r_out_s;
  assign out_flags = r_out_flags;
  assign out_tag   = r_out_tag;

  // Queue payload carries no reset; fu_* are masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_a[r_wptr]   <= in_a;
      r_b[r_wptr]   <= in_b;
      r_sel[r_wptr] <= in_sel;
      r_tag[r_wptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_s     <= '0;
      r_out_flags <= '0;
      r_out_tag   <= '0;
    end else if (flush) begin
      r_out_vld <= 1'b0;
    end else if (w_pop) begin
      r_out_vld   <= 1'b1;
      r_out_s     <= fu_s;
      r_out_flags <= {fu_c, fu_v, fu_n, fu_z};
      r_out_tag   <= r_tag[r_rptr];
    end else if (r_out_vld && out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

endmodule
